reel_sequencer: RTL and testbench

- Spin controller for the three slot-machine reel columns; produces the c1/c2/c3 symbol values the game FSM compares.
- On a lever edge it spins all reels at a fast rate, then decelerates and stops them one at a time, left to right.
- Signals completion with a one-cycle done pulse. The game FSM leaves its spinning state on that pulse instead of a fixed timeout.

---
 rtl/reel_sequencer_pkg.sv | 33 +++
 rtl/reel_sequencer_reel_channel.sv | 126 ++++++++++++
 rtl/reel_sequencer.sv | 132 +++++++++++++
 tb/tb_reel_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reel_sequencer_pkg.sv
// Shared types, constants and the LFSR step function for the reel spin controller.
package slot_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_FAST = 2'd1,
    R_SLOW = 2'd2,
    R_STOP = 2'd3
  } reel_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  localparam int NUM_REELS = 3;
  localparam int LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  // Width of the per-reel fast step length and step counter.
  localparam int LEN_W     = 16;
  // LFSR bits consumed per reel for the random extra fast steps (0..7).
  localparam int RAND_BITS = 3;

  // One shift of the 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/reel_sequencer_reel_channel.sv
// One reel column: steps its symbol at a fixed fast period for fast_len steps,
// then decelerates by doubling the period on each of SLOW_STEPS steps and stops.
module reel_channel
  import slot_pkg::*;
#(
  parameter int SYM_W       = 3,
  parameter int NUM_SYMBOLS = 6,
  parameter int CNT_W       = 27,
  parameter int FAST_PERIOD = 600000,
  parameter int SLOW_STEPS  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [LEN_W-1:0] fast_len,
  output logic [SYM_W-1:0] sym,
  output logic             stopped,
  output logic             active,
  output logic             last_step
);

  reel_mode_t       mode_r,   mode_nxt_s;
  logic [CNT_W-1:0] cnt_r,    cnt_nxt_s;
  logic [CNT_W-1:0] period_r, period_nxt_s;
  logic [LEN_W-1:0] step_r,   step_nxt_s;
  logic [LEN_W-1:0] len_r,    len_nxt_s;
  logic [SYM_W-1:0] sym_r,    sym_nxt_s;
  logic             active_r;

  logic             tick_s;
  logic [LEN_W-1:0] step_inc_s;
  logic [SYM_W-1:0] sym_inc_s;

  // A step is due when the period counter reaches the end of the current period.
  assign tick_s     = (cnt_r == (period_r - CNT_W'(1)));
  assign step_inc_s = step_r + LEN_W'(1);
  assign sym_inc_s  = (sym_r == SYM_W'(NUM_SYMBOLS - 1)) ? {SYM_W{1'b0}} : (sym_r + SYM_W'(1));

  assign sym       = sym_r;
  assign stopped   = (mode_r == R_STOP);
  assign active    = active_r;
  // Flags the cycle whose step puts this reel into R_STOP.
  assign last_step = (mode_r == R_SLOW) && tick_s && (step_inc_s == LEN_W'(SLOW_STEPS));

  // Next-state logic for mode, counters and symbol.
  always_comb begin
    mode_nxt_s   = mode_r;
    cnt_nxt_s    = cnt_r;
    period_nxt_s = period_r;
    step_nxt_s   = step_r;
    len_nxt_s    = len_r;
    sym_nxt_s    = sym_r;
    if (go) begin
      // Symbol is intentionally kept: each spin continues from the held value.
      mode_nxt_s   = R_FAST;
      cnt_nxt_s    = {CNT_W{1'b0}};
      period_nxt_s = CNT_W'(FAST_PERIOD);
      step_nxt_s   = {LEN_W{1'b0}};
      len_nxt_s    = fast_len;
    end else begin
      case (mode_r)
        R_FAST: begin
          if (tick_s) begin
            sym_nxt_s = sym_inc_s;
            cnt_nxt_s = {CNT_W{1'b0}};
            if (step_inc_s == len_r) begin
              mode_nxt_s   = R_SLOW;
              period_nxt_s = CNT_W'(2 * FAST_PERIOD);
              step_nxt_s   = {LEN_W{1'b0}};
            end else begin
              step_nxt_s = step_inc_s;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        R_SLOW: begin
          if (tick_s) begin
            sym_nxt_s    = sym_inc_s;
            cnt_nxt_s    = {CNT_W{1'b0}};
            period_nxt_s = {period_r[CNT_W-2:0], 1'b0};
            if (step_inc_s == LEN_W'(SLOW_STEPS)) begin
              mode_nxt_s = R_STOP;
              step_nxt_s = {LEN_W{1'b0}};
            end else begin
              step_nxt_s = step_inc_s;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        R_IDLE: begin
          mode_nxt_s = R_IDLE;
        end
        R_STOP: begin
          mode_nxt_s = R_STOP;
        end
        default: begin
          mode_nxt_s = R_IDLE;
        end
      endcase
    end
  end

  // Reel state registers; spinning indication is registered from the next mode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_r   <= R_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      period_r <= CNT_W'(FAST_PERIOD);
      step_r   <= {LEN_W{1'b0}};
      len_r    <= {LEN_W{1'b0}};
      sym_r    <= {SYM_W{1'b0}};
      active_r <= 1'b0;
    end else begin
      mode_r   <= mode_nxt_s;
      cnt_r    <= cnt_nxt_s;
      period_r <= period_nxt_s;
      step_r   <= step_nxt_s;
      len_r    <= len_nxt_s;
      sym_r    <= sym_nxt_s;
      active_r <= (mode_nxt_s == R_FAST) || (mode_nxt_s == R_SLOW);
    end
  end

endmodule

// File: rtl/reel_sequencer.sv
// Spin controller for three reel columns: lever edge detect, free-running LFSR,
// and the IDLE/SPIN/DONE controller that launches the reels and reports completion.
module reel_sequencer
  import slot_pkg::*;
#(
  parameter int SYM_W         = 3,
  parameter int NUM_SYMBOLS   = 6,
  parameter int CNT_W         = 27,
  parameter int FAST_PERIOD   = 600000,
  parameter int SPIN_STEPS    = 40,
  parameter int STAGGER_STEPS = 8,
  parameter int SLOW_STEPS    = 5,
  parameter int RAND_EN       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [SYM_W-1:0] c1,
  output logic [SYM_W-1:0] c2,
  output logic [SYM_W-1:0] c3,
  output logic [2:0]       spinning,
  output logic             busy,
  output logic             done
);

  ctrl_state_t          state_r, state_nxt_s;
  logic                 start_q_r;
  logic [LFSR_W-1:0]    lfsr_r;
  logic                 busy_r, busy_nxt_s;
  logic                 done_r, done_nxt_s;

  logic                 edge_s;
  logic                 go_s;
  logic                 all_stopped_s;
  logic                 last_s;
  logic [NUM_REELS-1:0] stopped_s;
  logic [NUM_REELS-1:0] last_step_s;
  logic [NUM_REELS-1:0] active_s;
  logic [SYM_W-1:0]     sym_s      [NUM_REELS];
  logic [LEN_W-1:0]     fast_len_s [NUM_REELS];

  assign edge_s        = start & ~start_q_r;
  assign all_stopped_s = &stopped_s;
  // True only in the single cycle where the final reel(s) take their last step.
  assign last_s        = (&(stopped_s | last_step_s)) & ~all_stopped_s;

  for (genvar gi = 0; gi < NUM_REELS; gi++) begin : g_reel
    logic [LEN_W-1:0] rand_s;

    // Random extra steps come from a disjoint 3-bit slice of the LFSR per reel.
    assign rand_s = (RAND_EN != 0) ? LEN_W'(lfsr_r[RAND_BITS*gi +: RAND_BITS]) : {LEN_W{1'b0}};
    assign fast_len_s[gi] = LEN_W'(SPIN_STEPS + gi * STAGGER_STEPS) + rand_s;

    reel_channel #(
      .SYM_W       (SYM_W),
      .NUM_SYMBOLS (NUM_SYMBOLS),
      .CNT_W       (CNT_W),
      .FAST_PERIOD (FAST_PERIOD),
      .SLOW_STEPS  (SLOW_STEPS)
    ) u_reel (
      .clk       (clk),
      .reset     (reset),
      .go        (go_s),
      .fast_len  (fast_len_s[gi]),
      .sym       (sym_s[gi]),
      .stopped   (stopped_s[gi]),
      .active    (active_s[gi]),
      .last_step (last_step_s[gi])
    );
  end

  assign c1       = sym_s[0];
  assign c2       = sym_s[1];
  assign c3       = sym_s[2];
  assign spinning = active_s;
  assign busy     = busy_r;
  assign done     = done_r;

  // Controller next state, reel launch and next values of the status outputs.
  always_comb begin
    state_nxt_s = state_r;
    go_s        = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (edge_s) begin
          state_nxt_s = SPIN;
          go_s        = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      SPIN: begin
        // Lever edges during a spin are ignored.
        if (all_stopped_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SPIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    done_nxt_s = (state_r == SPIN) && last_s;
    busy_nxt_s = (state_nxt_s == SPIN) && !done_nxt_s;
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Lever edge register, free-running LFSR and registered busy/done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      start_q_r <= 1'b0;
      lfsr_r    <= LFSR_SEED;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      start_q_r <= start;
      lfsr_r    <= lfsr_next(lfsr_r);
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

endmodule

// File: tb/tb_reel_sequencer.sv
// Scoreboard bench: stimulus pushes the expected stop/done events, a negedge
// monitor pops and checks them as the reels stop and done pulses.
module tb_reel_sequencer;

  localparam int SYM_W    = 3;
  localparam int NSYM     = 6;
  localparam int CNT_W    = 27;
  localparam int FP       = 4;
  localparam int SPIN     = 6;
  localparam int STAG     = 8;
  localparam int SLOW     = 2;
  // Cycles of deceleration expressed in fast periods: 2 + 4 + ... + 2**SLOW.
  localparam int SLOW_SUM = (2 ** (SLOW + 1)) - 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic sel = 1'b0;

  logic [SYM_W-1:0] c1_a, c2_a, c3_a, c1_b, c2_b, c3_b;
  logic [2:0]       sp_a, sp_b;
  logic             busy_a, busy_b, done_a, done_b;

  reel_sequencer #(
    .SYM_W(SYM_W), .NUM_SYMBOLS(NSYM), .CNT_W(CNT_W), .FAST_PERIOD(FP),
    .SPIN_STEPS(SPIN), .STAGGER_STEPS(STAG), .SLOW_STEPS(SLOW), .RAND_EN(0)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .c1(c1_a), .c2(c2_a), .c3(c3_a),
    .spinning(sp_a), .busy(busy_a), .done(done_a)
  );

  reel_sequencer #(
    .SYM_W(SYM_W), .NUM_SYMBOLS(NSYM), .CNT_W(CNT_W), .FAST_PERIOD(FP),
    .SPIN_STEPS(SPIN), .STAGGER_STEPS(STAG), .SLOW_STEPS(SLOW), .RAND_EN(1)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .c1(c1_b), .c2(c2_b), .c3(c3_b),
    .spinning(sp_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Monitor view of whichever DUT is under test.
  logic [SYM_W-1:0] m_sym [3];
  logic [2:0]       m_sp;
  logic             m_busy, m_done;
  assign m_sym[0] = sel ? c1_b : c1_a;
  assign m_sym[1] = sel ? c2_b : c2_a;
  assign m_sym[2] = sel ? c3_b : c3_a;
  assign m_sp     = sel ? sp_b : sp_a;
  assign m_busy   = sel ? busy_b : busy_a;
  assign m_done   = sel ? done_b : done_a;

  typedef struct {
    int kind;   // 0: reel stop, 1: done pulse
    int reel;
    int t0;     // accept cycle
    int base;   // deterministic fast length
    int jit;    // allowed random extra steps
    int ssym;   // symbol at accept
  } ev_t;

  ev_t sb[$];
  int  model_sym [3];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  last_t0 = 0;
  int  last_stop = 0;
  logic rst_hit = 1'b1;
  logic [2:0] prev_sp = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_hit <= ~reset;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic on_stop(input int i);
    ev_t e;
    int el, fl, es;
    if (sb.size() == 0) begin
      chk("unexpected_stop", i, -1);
      return;
    end
    e = sb.pop_front();
    chk("stop_order", i, (e.kind == 0) ? e.reel : -2);
    if (e.kind == 0 && e.reel == i) begin
      el = cyc - e.t0 - 1;
      fl = el / FP - SLOW_SUM;
      chk("stop_phase", el % FP, 0);
      chk("fast_len_in_range", (fl >= e.base && fl <= e.base + e.jit) ? 1 : 0, 1);
      if (e.jit == 0) chk("stop_cycle", cyc, e.t0 + 1 + FP * (e.base + SLOW_SUM));
      es = (e.ssym + fl + SLOW) % NSYM;
      chk("final_sym", int'(m_sym[i]), es);
      model_sym[i] = es;
      last_stop = cyc;
    end
  endtask

  task automatic on_done();
    ev_t e;
    if (sb.size() == 0) begin
      chk("unexpected_done", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("done_order", e.kind, 1);
    chk("done_after_last_stop", cyc, last_stop);
    if (e.jit == 0) chk("done_cycle", cyc, e.t0 + 1 + FP * (e.base + SLOW_SUM));
    chk("busy_at_done", int'(m_busy), 0);
    chk("spinning_at_done", int'(m_sp), 0);
  endtask

  // Event monitor: reel stop = falling spinning bit; ignored across a reset edge.
  always @(negedge clk) begin
    if (!rst_hit) begin
      for (int i = 0; i < 3; i++) begin
        if (prev_sp[i] === 1'b1 && m_sp[i] === 1'b0) on_stop(i);
      end
      if (m_done === 1'b1) on_done();
    end
    prev_sp = m_sp;
  end

  task automatic do_reset();
    reset = 1'b0;
    sb.delete();
    model_sym = '{0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else start_a = v;
  endtask

  // Raise the lever now (cycle T) and queue the expected events of that spin.
  task automatic spin(input bit rnd, input bit hold);
    ev_t e;
    last_t0 = cyc;
    set_start(1'b1);
    for (int i = 0; i < 3; i++) begin
      e.kind = 0; e.reel = i; e.t0 = last_t0; e.base = SPIN + i * STAG;
      e.jit = rnd ? 7 : 0; e.ssym = model_sym[i];
      sb.push_back(e);
    end
    e.kind = 1; e.reel = 2; e.t0 = last_t0; e.base = SPIN + 2 * STAG;
    e.jit = rnd ? 7 : 0; e.ssym = 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk("busy_after_accept", int'(m_busy), 1);
    chk("spinning_after_accept", int'(m_sp), 7);
    if (!hold) set_start(1'b0);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("spin_completes", sb.size(), 0);
    sb.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_c1"}, int'(c1_a), 0);
    chk({tag, "_c2"}, int'(c2_a), 0);
    chk({tag, "_c3"}, int'(c3_a), 0);
    chk({tag, "_spinning"}, int'(sp_a), 0);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_done"}, int'(done_a), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    #1;
    // 1: reset values, then quiet idle
    do_reset();
    chk_zero("reset");
    chk("reset_b_spinning", int'(sp_b), 0);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if ({c1_a, c2_a, c3_a, sp_a, busy_a, done_a} !== '0) bad++;
    end
    chk("idle_stable", bad, 0);

    // 2: first spin -> 2,4,0 with done at T+113
    spin(1'b0, 1'b0);
    wait_done(300);
    chk("t2_c1", int'(c1_a), 2);

    // 3: second spin continues from held symbols -> 4,2,0
    spin(1'b0, 1'b0);
    wait_done(300);
    chk("t3_c1", int'(c1_a), 4);
    chk("t3_c2", int'(c2_a), 2);
    chk("t3_c3", int'(c3_a), 0);

    // 4: mid-spin edge at T+30, lever then held through DONE
    repeat (3) @(posedge clk);
    #1;
    spin(1'b0, 1'b0);
    wait_until(last_t0 + 30);
    start_a = 1'b1;
    wait_done(300);
    repeat (40) @(posedge clk);
    #1;
    chk("t4_no_restart_busy", int'(busy_a), 0);
    chk("t4_no_restart_spinning", int'(sp_a), 0);
    start_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 5: reset mid-spin at T+60, then a clean spin from zero
    spin(1'b0, 1'b0);
    wait_until(last_t0 + 60);
    reset = 1'b0;
    sb.delete();
    model_sym = '{0, 0, 0};
    @(posedge clk);
    #1;
    chk_zero("midspin_reset");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    spin(1'b0, 1'b0);
    wait_done(300);
    chk("t5_c2", int'(c2_a), 4);

    // 6: randomized extra steps on the RAND_EN=1 instance
    do_reset();
    sel = 1'b1;
    for (int n = 0; n < 20; n++) begin
      spin(1'b1, 1'b0);
      wait_done(400);
      repeat ($urandom_range(1, 20)) @(posedge clk);
      #1;
    end
    repeat (20) @(posedge clk);
    #1;
    chk("no_stray_events", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
